dco_square_gen: RTL



---
 rtl/dco_square_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/dco_square_gen.sv
// Digitally controlled square-wave oscillator for the DPLL loop.
// lead/lag pulses stretch or shrink the next output period by whole clk_50K cycles.
module dco_square_gen #(
    parameter int DIV_NOM = 8,
    parameter int CNT_W   = 8,
    parameter int ADJ_MAX = 2
) (
    input  logic             clk_50K,
    input  logic             rst,
    input  logic             enable,
    input  logic             lead,
    input  logic             lag,
    output logic             signal_out,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period_cnt
);

    localparam int ADJ_W = $clog2(ADJ_MAX + 1) + 1;
    localparam logic signed [ADJ_W:0] SUM_HI = (ADJ_W + 1)'(ADJ_MAX);
    localparam logic signed [ADJ_W:0] SUM_LO = (ADJ_W + 1)'(-ADJ_MAX);
    localparam logic [CNT_W-1:0] NOM = CNT_W'(DIV_NOM);

    if ((DIV_NOM - ADJ_MAX < 2) || (DIV_NOM + ADJ_MAX > (1 << CNT_W) - 1)) begin : g_bad_params
        $error("dco_square_gen: DIV_NOM/ADJ_MAX/CNT_W give an unreachable period");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_period;
    logic signed [ADJ_W-1:0]  r_adj;
    logic                     r_sig;
    logic                     r_edge;

    logic signed [ADJ_W:0]    w_sum;
    logic signed [ADJ_W-1:0]  w_adj_eff;
    logic [CNT_W-1:0]         w_period_nxt;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic                     w_wrap;

    // Pending adjustment including this cycle's pulse, clipped to +/-ADJ_MAX.
    always_comb begin
        w_sum = {r_adj[ADJ_W-1], r_adj};
        if (lead && !lag) begin
            w_sum = w_sum + (ADJ_W + 1)'(1);
        end else if (lag && !lead) begin
            w_sum = w_sum - (ADJ_W + 1)'(1);
        end
        if (w_sum > SUM_HI) begin
            w_sum = SUM_HI;
        end else if (w_sum < SUM_LO) begin
            w_sum = SUM_LO;
        end
        w_adj_eff = w_sum[ADJ_W-1:0];
    end

    assign w_period_nxt = NOM + {{(CNT_W - ADJ_W){w_adj_eff[ADJ_W-1]}}, w_adj_eff};
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_wrap       = (r_cnt == r_period - CNT_W'(1));

    always_ff @(posedge clk_50K or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_period <= NOM;
            r_adj    <= '0;
            r_sig    <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt    <= '0;
                    r_adj    <= '0;
                    r_period <= NOM;
                    r_sig    <= enable;
                    r_edge   <= enable;
                    if (enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_wrap) begin
                        r_cnt  <= w_cnt_inc;
                        r_adj  <= w_adj_eff;
                        r_sig  <= (w_cnt_inc < (r_period >> 1));
                        r_edge <= 1'b0;
                    end else if (enable) begin
                        r_cnt    <= '0;
                        r_period <= w_period_nxt;
                        r_adj    <= '0;
                        r_sig    <= 1'b1;
                        r_edge   <= 1'b1;
                    end else begin
                        // Disable only takes effect once the running period is complete.
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_period <= NOM;
                        r_adj    <= '0;
                        r_sig    <= 1'b0;
                        r_edge   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign signal_out = r_sig;
    assign edge_pulse = r_edge;
    assign period_cnt = r_cnt;

endmodule
